// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bor_in, LSB first, one bit per clock with start/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bor_in,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy,
   output logic             done
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, borrow_q, borrow_d, busy_q, busy_d, done_q, done_d;
   logic             bit_a, bit_b, bit_d, last;
   assign bit_a  = a_q[0];
   assign bit_b  = b_q[0];
   assign bit_d  = bit_a ^ bit_b ^ br_q;
   assign last   = cnt_q == CW'(WIDTH - 1);
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign busy   = busy_q;
   assign done   = done_q;
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      br_d     = br_q;
      r_d      = r_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            a_d     = a_in;
            b_d     = b_in;
            br_d    = bor_in;
            r_d     = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
            r_d   = {bit_d, r_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            // outputs are published only once the final bit is folded in
            if (last) begin
               diff_d   = r_d;
               borrow_d = br_d;
               done_d   = 1'b1;
               state_d  = DONE;
            end else begin
               busy_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         br_q     <= 1'b0;
         r_q      <= '0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         br_q     <= br_d;
         r_q      <= r_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a_in - b_in - bor_in` one bit per clock, LSB first. It is the inverse-operation companion to the 4-bit parallel adder. It shares the same operand/carry port style, and trades the parallel adder's single-cycle combinational path for a small FSM, a shift datapath and a start/done handshake. Results are registered and held until the next accepted operation.

## Interface
- `WIDTH`, default 4: operand and result width in bits (≥ 2).

- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset; asynchronous and active-high
- `start`  input  1  request; sampled only in IDLE
- `a_in`  input  WIDTH  minuend; latched when start is accepted
- `b_in`  input  WIDTH  subtrahend; latched when start is accepted
- `bor_in`  input  1  borrow-in; latched when start is accepted
- `diff`  output  WIDTH  registered difference, low WIDTH bits of `a - b - bor_in`
- `borrow`  output  1  registered borrow-out; 1 when `a < b + bor_in` (unsigned)
- `busy`  output  1  high while an operation is in progress
- `done`  output  1  one-cycle pulse: `diff`/`borrow` were just updated

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: processes WIDTH bits.
  - DONE: single cycle, then returns to IDLE.
- IDLE, start=1 at a rising edge:
  - Latch `a_in`→A, `b_in`→B, `bor_in`→BR.
  - Clear the bit counter and the internal result shift register R.
  - Go to SHIFT.
- IDLE, start=0: remain in IDLE.
- SHIFT, each edge, with a=A[0], b=B[0]:
  - d = a^b^BR
  - BR ← (~a & b) | (~(a^b) & BR)
  - R ← {d, R[WIDTH-1:1]}
  - A, B shift right by 1; counter increments.
- On the edge that processes bit WIDTH-1:
  - `diff` ← final R (including that bit); `borrow` ← final BR.
  - Go to DONE.
- DONE: next edge → IDLE unconditionally.
- `diff`/`borrow` change only on the completing edge. Partial results are never visible on outputs.
- `start` in SHIFT or DONE is ignored. It is not queued.
- Input changes after acceptance have no effect on the running operation.
- Counter width is clog2(WIDTH), minimum 1. No wrap beyond WIDTH-1 is used.

## Timing
- Reset values (asynchronous, immediate on rst=1):
  - `diff`=0, `borrow`=0, `busy`=0, `done`=0.
  - State=IDLE; A, B, BR, R and the counter cleared.
- `rst` asserted mid-operation aborts it. After release the block is in IDLE, outputs at their reset values, and it can accept start on the first edge after deassertion.
- Start accepted at edge k:
  - `busy`=1 from edge k through edge k+WIDTH-1.
  - Edge k+WIDTH: `busy`=0, `done`=1, `diff`/`borrow` valid.
  - Edge k+WIDTH+1: `done`=0, state IDLE.
- Latency start→done = WIDTH cycles.
- Earliest next acceptance is edge k+WIDTH+2 (start sampled in IDLE). Throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.
- `busy`, `done`, `diff` and `borrow` are all driven from flops; no combinational path from inputs to outputs.

## Test plan
- Reset check: hold rst=1 with random inputs and start=1 → `diff`=0000, `borrow`=0, `busy`=0, `done`=0. Release rst, pulse start with 0101, 0011, bor 0 → `done` exactly 4 cycles after the start edge, `diff`=0010, `borrow`=0.
- Underflow (WIDTH=4): 0011 − 0101, bor 0 → `diff`=1110, `borrow`=1. Separately, 0000 − 0000, bor 1 → `diff`=1111, `borrow`=1.
- Full-scale operands: 1111 − 1111, bor 0 → `diff`=0000, `borrow`=0. Separately, 1010 − 0101, bor 1 → `diff`=0100, `borrow`=0.
- Operand stability: start with 1000 − 0001, bor 0, then change inputs and re-assert start every cycle while busy. Required:
  - Single done pulse with `diff`=0111, `borrow`=0.
  - No second operation until start is seen in IDLE.
  - `diff` holds 0111 until then.
- Reset mid-operation: assert rst 2 cycles after accepting start → outputs return to zero immediately, no `done` pulse. After release, a new start with 0110 − 0010, bor 0 → `diff`=0100 after 4 cycles.
- Exhaustive sweep (WIDTH=4): all 512 combinations of a, b and bor_in, each checked against `{borrow,diff}` = `(a − b − bor_in) mod 32` with `borrow` = (a < b + bor_in). Back-to-back starts at the earliest legal edge confirm the WIDTH+2 cycle cadence.
